// File: rtl/alu_mc_top.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc_top
//  Purpose  : Multi-cycle ALU with valid/ready handshakes. Single-cycle ops
//             register their result at the accepting edge. Signed divide
//             runs a restoring divider, one quotient bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc_top #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    input  logic                 OUT_READY,
    output logic                 OUT_VALID,
    output logic [2*WIDTH-1:0]   ALU_OUT,
    output logic                 Carry_OUT,
    output logic                 Arith_Flag,
    output logic                 Logic_Flag,
    output logic                 CMP_Flag,
    output logic                 SHIFT_Flag,
    output logic                 DIV_ERR
);
    localparam int          SHW     = $clog2(WIDTH);
    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_BUSY  = 2'd1;
    localparam logic [1:0]  c_HOLD  = 2'd2;
    localparam logic [SHW:0] c_WIDTH = (SHW+1)'(WIDTH);

    logic [1:0]           r_state, w_next_state;
    logic                 w_accept, w_div_start;

    // Single-cycle datapath
    logic [SHW-1:0]       w_sh;
    logic [WIDTH:0]       w_add_u, w_sub_u;
    logic [2*WIDTH-1:0]   w_a_ext, w_b_ext, w_prod;
    logic [WIDTH-1:0]     w_sra, w_rol;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_carry, w_err;

    // Iterative divider
    logic [WIDTH-1:0]     r_quo, r_rem, r_dvs;
    logic                 r_neg_q, r_neg_r;
    logic [SHW-1:0]       r_cnt;
    logic [WIDTH:0]       w_trial;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_nx, w_quo_nx, w_quo_fin, w_rem_fin;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;

    // Held result registers
    logic [2*WIDTH-1:0]   r_alu_out;
    logic                 r_carry, r_arith, r_logic, r_cmp, r_shift, r_err;

    assign w_accept    = IN_VALID && IN_READY;
    assign w_div_start = w_accept && (ALU_FUN == 4'b0011) && (B != '0);

    assign w_sh    = B[SHW-1:0];
    assign w_add_u = {1'b0, A} + {1'b0, B};
    assign w_sub_u = {1'b0, A} - {1'b0, B};
    assign w_a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    assign w_b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    // Low 2*WIDTH bits of the product of sign-extended operands is the signed product
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_sra   = $signed(A) >>> w_sh;
    assign w_rol   = (A << w_sh) | (A >> (c_WIDTH - {1'b0, w_sh}));

    assign w_abs_a = A[WIDTH-1] ? -A : A;
    assign w_abs_b = B[WIDTH-1] ? -B : B;

    // Restoring-divider step: shift next dividend bit into the partial remainder
    assign w_trial   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = w_trial >= {1'b0, r_dvs};
    assign w_rem_nx  = w_ge ? (w_trial[WIDTH-1:0] - r_dvs) : w_trial[WIDTH-1:0];
    assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
    assign w_quo_fin = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_rem_fin = r_neg_r ? -w_rem_nx : w_rem_nx;

    // Result of every op that completes at the accepting edge
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (ALU_FUN)
            4'b0000: begin
                // Signed sum's sign bit recovered from operand signs and the unsigned carry
                w_res   = {{WIDTH{A[WIDTH-1] ^ B[WIDTH-1] ^ w_add_u[WIDTH]}}, w_add_u[WIDTH-1:0]};
                w_carry = w_add_u[WIDTH];
            end
            4'b0001: begin
                w_res   = {{WIDTH{A[WIDTH-1] ^ B[WIDTH-1] ^ w_sub_u[WIDTH]}}, w_sub_u[WIDTH-1:0]};
                w_carry = w_sub_u[WIDTH];
            end
            4'b0010: w_res = w_prod;
            4'b0011: begin
                // Only reached with B == 0; non-zero divisors go to the iterative path
                w_res = {A, {WIDTH{1'b1}}};
                w_err = 1'b1;
            end
            4'b0100: w_res = {{WIDTH{1'b0}}, A & B};
            4'b0101: w_res = {{WIDTH{1'b0}}, A | B};
            4'b0110: w_res = {{WIDTH{1'b0}}, ~(A & B)};
            4'b0111: w_res = {{WIDTH{1'b0}}, ~(A | B)};
            4'b1000: w_res = '0;
            4'b1001: w_res = {{(2*WIDTH-2){1'b0}}, (A == B) ? 2'd1 : 2'd0};
            4'b1010: w_res = {{(2*WIDTH-2){1'b0}}, ($signed(A) > $signed(B)) ? 2'd2 : 2'd0};
            4'b1011: w_res = {{(2*WIDTH-2){1'b0}}, ($signed(A) < $signed(B)) ? 2'd3 : 2'd0};
            4'b1100: w_res = {{WIDTH{1'b0}}, A >> w_sh};
            4'b1101: w_res = {{WIDTH{1'b0}}, A << w_sh};
            4'b1110: w_res = {{WIDTH{1'b0}}, w_sra};
            default: w_res = {{WIDTH{1'b0}}, w_rol};
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= c_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_next_state = w_div_start ? c_BUSY : c_HOLD;
            c_BUSY: if (r_cnt == '0) w_next_state = c_HOLD;
            c_HOLD: begin
                if (w_accept)       w_next_state = w_div_start ? c_BUSY : c_HOLD;
                else if (OUT_READY) w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (r_state)
            c_IDLE: IN_READY = 1'b1;
            c_HOLD: begin
                IN_READY  = OUT_READY;
                OUT_VALID = 1'b1;
            end
            default: IN_READY = 1'b0;
        endcase
    end

    // Result registers and divider iteration
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_alu_out <= '0;
            r_carry   <= 1'b0;
            r_arith   <= 1'b0;
            r_logic   <= 1'b0;
            r_cmp     <= 1'b0;
            r_shift   <= 1'b0;
            r_err     <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
        end else if (w_div_start) begin
            r_quo   <= w_abs_a;
            r_rem   <= '0;
            r_dvs   <= w_abs_b;
            r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_r <= A[WIDTH-1];
            r_cnt   <= SHW'(WIDTH-1);
        end else if (w_accept) begin
            r_alu_out <= w_res;
            r_carry   <= w_carry;
            r_err     <= w_err;
            r_arith   <= (ALU_FUN[3:2] == 2'b00);
            r_logic   <= (ALU_FUN[3:2] == 2'b01);
            r_cmp     <= (ALU_FUN[3:2] == 2'b10);
            r_shift   <= (ALU_FUN[3:2] == 2'b11);
        end else if (r_state == c_BUSY) begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt - SHW'(1);
            if (r_cnt == '0) begin
                r_alu_out <= {w_rem_fin, w_quo_fin};
                r_carry   <= 1'b0;
                r_err     <= 1'b0;
                r_arith   <= 1'b1;
                r_logic   <= 1'b0;
                r_cmp     <= 1'b0;
                r_shift   <= 1'b0;
            end
        end
    end

    assign ALU_OUT    = r_alu_out;
    assign Carry_OUT  = r_carry;
    assign Arith_Flag = r_arith;
    assign Logic_Flag = r_logic;
    assign CMP_Flag   = r_cmp;
    assign SHIFT_Flag = r_shift;
    assign DIV_ERR    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc_top
//  Purpose  : Directed scoreboard bench for alu_mc_top (WIDTH = 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc_top;
    localparam int WIDTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ALU_FUN = '0;
    logic        IN_READY, OUT_VALID, Carry_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, DIV_ERR;
    logic [31:0] ALU_OUT;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        ar;
        logic        lg;
        logic        cm;
        logic        sh;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    alu_mc_top #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .OUT_READY  (OUT_READY),
        .OUT_VALID  (OUT_VALID),
        .ALU_OUT    (ALU_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_Flag (Logic_Flag),
        .CMP_Flag   (CMP_Flag),
        .SHIFT_Flag (SHIFT_Flag),
        .DIV_ERR    (DIV_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic c, input int cls, input logic er);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.ar  = (cls == 0);
        e.lg  = (cls == 1);
        e.cm  = (cls == 2);
        e.sh  = (cls == 3);
        e.er  = er;
        return e;
    endfunction

    // Monitor: pop and compare on every output handshake
    always @(negedge CLK) begin
        if (RST && OUT_VALID && OUT_READY) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", ALU_OUT);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", ALU_OUT, e.res);
                chk("flags", {26'd0, Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, DIV_ERR},
                             {26'd0, e.c, e.ar, e.lg, e.cm, e.sh, e.er});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request and hold it until transferred
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                        input exp_t e, output int acc);
        logic rdy;
        acc = -1;
        A = a; B = b; ALU_FUN = f; IN_VALID = 1'b1;
        q.push_back(e);
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            rdy = IN_READY;
            @(posedge CLK);
            #1;
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        IN_VALID = 1'b0;
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Count cycles from acceptance to OUT_VALID; for long ops, poke junk requests while busy
    task automatic wait_out(input int lat, input string nm);
        int n;
        bit got;
        n = 1;
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                got = 1'b1;
                break;
            end
            if (lat > 1 && n == 3) chk("in_ready_busy", {31'd0, IN_READY}, 32'd0);
            @(posedge CLK);
            #1;
            n++;
            if (lat > 1 && n == 2) begin
                IN_VALID = 1'b1; A = 16'd1; B = 16'd1; ALU_FUN = 4'b0000;
            end
            if (lat > 1 && n == 6) IN_VALID = 1'b0;
        end
        chk(nm, got ? 32'(n) : 32'hFFFF_FFFF, 32'(lat));
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                       input exp_t e, input int lat, input string nm);
        int acc;
        send(a, b, f, e, acc);
        wait_out(lat, nm);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int c1, c2, c3, acc;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_alu_out", ALU_OUT, 32'd0);
        chk("rst_flags", {26'd0, Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, DIV_ERR}, 32'd0);
        chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        tick();
        RST = 1'b1;

        // Divide, first request after reset release
        run(16'd100, 16'hFFF6, 4'b0011, mk(32'h0000FFF6, 1'b0, 0, 1'b0), 17, "lat_div");
        run(16'd7,   16'd0,    4'b0011, mk(32'h0007FFFF, 1'b0, 0, 1'b1), 1,  "lat_div0");

        // Back-to-back
        send(16'd10,   16'd15, 4'b0000, mk(32'h00000019, 1'b0, 0, 1'b0), c1);
        send(16'hFFF6, 16'd20, 4'b0010, mk(32'hFFFFFF38, 1'b0, 0, 1'b0), c2);
        send(16'hFFFF, 16'd1,  4'b0000, mk(32'h00000000, 1'b1, 0, 1'b0), c3);
        chk("b2b_gap1", 32'(c2 - c1), 32'd1);
        chk("b2b_gap2", 32'(c3 - c2), 32'd1);
        tick();
        tick();

        run(16'd5,     16'd7,     4'b0001, mk(32'hFFFFFFFE, 1'b1, 0, 1'b0), 1,  "lat_sub");
        run(16'h8000,  16'h8000,  4'b0010, mk(32'h40000000, 1'b0, 0, 1'b0), 1,  "lat_mul");
        run(16'h8000,  16'hFFFF,  4'b0011, mk(32'h00008000, 1'b0, 0, 1'b0), 17, "lat_div_ovf");
        run(16'hFFF9,  16'd2,     4'b0011, mk(32'hFFFFFFFD, 1'b0, 0, 1'b0), 17, "lat_div_neg");
        run(16'h00FF,  16'h0F0F,  4'b0101, mk(32'h00000FFF, 1'b0, 1, 1'b0), 1,  "lat_or");
        run(16'h00FF,  16'h0F0F,  4'b0110, mk(32'h0000FFF0, 1'b0, 1, 1'b0), 1,  "lat_nand");
        run(16'h00FF,  16'h0F0F,  4'b0111, mk(32'h0000F000, 1'b0, 1, 1'b0), 1,  "lat_nor");
        run(16'h1234,  16'h5678,  4'b1000, mk(32'h00000000, 1'b0, 2, 1'b0), 1,  "lat_nop");
        run(16'd5,     16'd5,     4'b1001, mk(32'h00000001, 1'b0, 2, 1'b0), 1,  "lat_eq");
        run(16'hFFFB,  16'd3,     4'b1010, mk(32'h00000000, 1'b0, 2, 1'b0), 1,  "lat_gt");
        run(16'hFFFB,  16'd3,     4'b1011, mk(32'h00000003, 1'b0, 2, 1'b0), 1,  "lat_lt");
        run(16'h8002,  16'd1,     4'b1100, mk(32'h00004001, 1'b0, 3, 1'b0), 1,  "lat_srl");
        run(16'h8002,  16'd1,     4'b1101, mk(32'h00000004, 1'b0, 3, 1'b0), 1,  "lat_shl");
        run(16'h8002,  16'd1,     4'b1110, mk(32'h0000C001, 1'b0, 3, 1'b0), 1,  "lat_sra");
        run(16'h8002,  16'd4,     4'b1111, mk(32'h00000028, 1'b0, 3, 1'b0), 1,  "lat_rol");

        // Back-pressure: result must hold while OUT_READY is low
        OUT_READY = 1'b0;
        send(16'hF0F0, 16'h0FF0, 4'b0100, mk(32'h000000F0, 1'b0, 1, 1'b0), acc);
        wait_out(1, "lat_and");
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge CLK);
            chk("hold_alu_out", ALU_OUT, 32'h000000F0);
            chk("hold_flags", {26'd0, Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, DIV_ERR}, 32'h00000008);
            chk("hold_in_ready", {31'd0, IN_READY}, 32'd0);
        end
        tick();
        OUT_READY = 1'b1;
        tick();
        @(negedge CLK);
        chk("idle_out_valid", {31'd0, OUT_VALID}, 32'd0);
        tick();

        // Asynchronous reset in the middle of a divide
        run(16'hFFFB, 16'd3, 4'b1011, mk(32'h00000003, 1'b0, 2, 1'b0), 1, "lat_lt2");
        send(16'd100, 16'hFFF6, 4'b0011, mk(32'h0000FFF6, 1'b0, 0, 1'b0), acc);
        repeat (4) tick();
        RST = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("arst_alu_out", ALU_OUT, 32'd0);
        chk("arst_flags", {26'd0, Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, DIV_ERR}, 32'd0);
        chk("arst_in_ready", {31'd0, IN_READY}, 32'd1);
        q.delete();
        repeat (2) tick();
        RST = 1'b1;
        run(16'd3, 16'd4, 4'b0000, mk(32'h00000007, 1'b0, 0, 1'b0), 1, "lat_after_rst");

        repeat (2) tick();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
